// File: rtl/ps2_autotype_pkg.sv
// ps2_autotype_pkg: scancode constants, FSM state encoding and the
// ASCII-to-scancode lookup shared by the autotype keystroke injector.
package ps2_autotype_pkg;

   // PS/2 set-2 scancodes used by the injector
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_COMMA  = 8'h41;
   localparam logic [7:0] SC_PERIOD = 8'h49;
   localparam logic [7:0] SC_SLASH  = 8'h4A;
   localparam logic [7:0] SC_SEMI   = 8'h4C;
   localparam logic [7:0] SC_LBRACK = 8'h54;
   localparam logic [7:0] SC_RBRACK = 8'h5B;
   localparam logic [7:0] SC_BSLASH = 8'h5D;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_SHIFT_DN = 3'd2,
      ST_KEY_DN   = 3'd3,
      ST_KEY_UP   = 3'd4,
      ST_SHIFT_UP = 3'd5
   } state_t;

   // Lookup result: valid=0 means the character has no key on the machine
   typedef struct packed {
      logic       valid;
      logic       shift;
      logic [7:0] code;
   } sc_t;

   function automatic sc_t ascii_to_sc(input logic [7:0] ch);
      sc_t        r;
      logic [7:0] up;
      r.valid = 1'b1;
      r.shift = 1'b0;
      r.code  = 8'h00;
      // lower-case letters share the key of their upper-case form
      up = (ch >= 8'h61 && ch <= 8'h7A) ? (ch - 8'h20) : ch;
      case (up)
         8'h41: r.code = 8'h1C;  8'h42: r.code = 8'h32;  8'h43: r.code = 8'h21;
         8'h44: r.code = 8'h23;  8'h45: r.code = 8'h24;  8'h46: r.code = 8'h2B;
         8'h47: r.code = 8'h34;  8'h48: r.code = 8'h33;  8'h49: r.code = 8'h43;
         8'h4A: r.code = 8'h3B;  8'h4B: r.code = 8'h42;  8'h4C: r.code = 8'h4B;
         8'h4D: r.code = 8'h3A;  8'h4E: r.code = 8'h31;  8'h4F: r.code = 8'h44;
         8'h50: r.code = 8'h4D;  8'h51: r.code = 8'h15;  8'h52: r.code = 8'h2D;
         8'h53: r.code = 8'h1B;  8'h54: r.code = 8'h2C;  8'h55: r.code = 8'h3C;
         8'h56: r.code = 8'h2A;  8'h57: r.code = 8'h1D;  8'h58: r.code = 8'h22;
         8'h59: r.code = 8'h35;  8'h5A: r.code = 8'h1A;
         8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;  8'h32: r.code = 8'h1E;
         8'h33: r.code = 8'h26;  8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;
         8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;  8'h38: r.code = 8'h3E;
         8'h39: r.code = 8'h46;
         8'h20: r.code = SC_SPACE;
         8'h0D: r.code = SC_ENTER;
         8'h08: r.code = SC_BKSP;
         8'h2C: r.code = SC_COMMA;
         8'h2E: r.code = SC_PERIOD;
         8'h2F: r.code = SC_SLASH;
         8'h3B: r.code = SC_SEMI;
         8'h5B: r.code = SC_LBRACK;
         8'h5D: r.code = SC_RBRACK;
         8'h5C: r.code = SC_BSLASH;
         8'h3A: begin r.shift = 1'b1; r.code = SC_SEMI; end
         8'h40: begin r.shift = 1'b1; r.code = 8'h1E;   end
         8'h5E: begin r.shift = 1'b1; r.code = 8'h36;   end
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/autotype_fifo.sv
// autotype_fifo: synchronous character FIFO with asynchronous reset and a
// synchronous flush. dout shows the head entry whenever empty is low.
module autotype_fifo
   import ps2_autotype_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   // extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   // pointer update; flush discards every buffered entry
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write, no reset needed on the data array
   always_ff @(posedge clk_sys) begin
      if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ps2_autotype.sv
// ps2_autotype: buffers pasted ASCII characters and replays them as
// MiSTer ps2_key press/release events with matrix-scan-friendly dwell times.
// Optional macro PS2_AUTOTYPE_ABORT_EN adds an abort input that flushes the
// buffer and releases any held key.
module ps2_autotype
   import ps2_autotype_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int HOLD_CYC   = 1000000,
   parameter int GAP_CYC    = 1000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
`ifdef PS2_AUTOTYPE_ABORT_EN
   input  logic        abort,
`endif
   output logic        char_ready,
   output logic [10:0] ps2_key,
   output logic        busy,
   output logic [7:0]  drop_cnt,
   output logic [2:0]  fsm_state
);

   // Handshake: a character is taken on a clk_sys edge where char_valid and
   // char_ready are both high; char_ready depends only on FIFO full (and
   // abort), never on char_valid.

   localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
   localparam int GAP_EFF  = (GAP_CYC < 1) ? 1 : GAP_CYC;
   localparam int CNT_MAX  = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
   localparam int CW       = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_EFF - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_EFF - 1);

   state_t       state_q;
   state_t       state_d;
   logic [CW-1:0] cnt_q;
   logic [10:0]  key_q;
   logic [7:0]   drop_q;
   sc_t          lut_q;
   logic         avail_q;
   logic         abort_i;

   logic         fifo_full;
   logic         fifo_empty;
   logic [7:0]   fifo_dout;
   logic         push;
   logic         pop;
   logic         emit;
   logic         emit_press;
   logic [7:0]   emit_code;
   logic         drop_inc;
   logic         dwell_done;

`ifdef PS2_AUTOTYPE_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign char_ready = ~fifo_full & ~abort_i;
   assign push       = char_valid & char_ready;
   assign dwell_done = (cnt_q == '0);
   assign ps2_key    = key_q;
   assign drop_cnt   = drop_q;
   assign busy       = ~fifo_empty | (state_q != ST_IDLE);
   assign fsm_state  = state_q;

   autotype_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (abort_i),
      .din     (char_in),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // state register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next state, FIFO pop and event selection
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      emit       = 1'b0;
      emit_press = 1'b0;
      emit_code  = lut_q.code;
      drop_inc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // avail_q is the registered FIFO status; a fresh write into an
            // empty FIFO is seen one cycle later
            if (avail_q && !fifo_empty && !abort_i) begin
               pop     = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (!lut_q.valid) begin
               drop_inc = 1'b1;
               state_d  = ST_IDLE;
            end else if (lut_q.shift) begin
               emit       = 1'b1;
               emit_press = 1'b1;
               emit_code  = SC_LSHIFT;
               state_d    = ST_SHIFT_DN;
            end else begin
               emit       = 1'b1;
               emit_press = 1'b1;
               state_d    = ST_KEY_DN;
            end
         end
         ST_SHIFT_DN: begin
            if (abort_i) begin
               emit      = 1'b1;
               emit_code = SC_LSHIFT;
               state_d   = ST_SHIFT_UP;
            end else if (dwell_done) begin
               emit       = 1'b1;
               emit_press = 1'b1;
               state_d    = ST_KEY_DN;
            end
         end
         ST_KEY_DN: begin
            if (abort_i || dwell_done) begin
               emit    = 1'b1;
               state_d = ST_KEY_UP;
            end
         end
         ST_KEY_UP: begin
            if (dwell_done) begin
               if (lut_q.shift) begin
                  emit      = 1'b1;
                  emit_code = SC_LSHIFT;
                  state_d   = ST_SHIFT_UP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SHIFT_UP: begin
            if (dwell_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // dwell counter: presses hold, releases gap; next event when it hits zero
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)              cnt_q <= '0;
      else if (emit)          cnt_q <= emit_press ? HOLD_LD : GAP_LD;
      else if (!dwell_done)   cnt_q <= cnt_q - CW'(1);
   end

   // event word: toggle bit flips once per emitted event
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)     key_q <= '0;
      else if (emit) key_q <= {~key_q[10], emit_press, 1'b0, emit_code};
   end

   // lookup of the popped character plus registered FIFO status
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         lut_q   <= '0;
         avail_q <= 1'b0;
      end else begin
         avail_q <= ~fifo_empty;
         if (pop) lut_q <= ascii_to_sc(fifo_dout);
      end
   end

   // saturating count of discarded characters
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                          drop_q <= '0;
      else if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
   end

endmodule

// File: tb/tb_ps2_autotype.sv
// tb_ps2_autotype: directed bench for ps2_autotype with 8-cycle hold/gap.
// Abort steps compile in only when PS2_AUTOTYPE_ABORT_EN is defined.
module tb_ps2_autotype;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [10:0] ps2_key;
   logic        busy;
   logic [7:0]  drop_cnt;
   logic [2:0]  fsm_state;
`ifdef PS2_AUTOTYPE_ABORT_EN
   logic        abort;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [10:0] ev_q[$];
   int          ev_t[$];
   logic [10:0] exp_q[$];
   int          exp_dt_q[$];
   logic        prev_tog = 1'b0;
   logic        tog = 1'b0;
   int          last_t = 0;

   ps2_autotype #(.FIFO_DEPTH(16), .HOLD_CYC(8), .GAP_CYC(8)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
`ifdef PS2_AUTOTYPE_ABORT_EN
      .abort      (abort),
`endif
      .char_ready (char_ready),
      .ps2_key    (ps2_key),
      .busy       (busy),
      .drop_cnt   (drop_cnt),
      .fsm_state  (fsm_state)
   );

   // clock and cycle index (cyc = number of rising edges so far)
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // event monitor: records every toggle of ps2_key[10] with its edge index
   always @(posedge clk_sys) begin
      #1;
      if (reset) prev_tog = ps2_key[10];
      else if (ps2_key[10] !== prev_tog) begin
         ev_q.push_back(ps2_key);
         ev_t.push_back(cyc);
         prev_tog = ps2_key[10];
      end
   end

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, req);
      end
   endtask

   task automatic send_char(input logic [7:0] c, output int acc);
      @(negedge clk_sys);
      char_in    = c;
      char_valid = 1'b1;
      chk("send_ready", {31'd0, char_ready}, 32'd1);
      @(negedge clk_sys);
      acc        = cyc;
      char_valid = 1'b0;
   endtask

   task automatic get_ev(output logic [10:0] w, output int t);
      int n = 0;
      while (ev_q.size() == 0 && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (ev_q.size() == 0) begin
         chk("ev_timeout", ev_q.size(), 32'd1);
         w = 'x;
         t = -1;
      end else begin
         w = ev_q.pop_front();
         t = ev_t.pop_front();
      end
   endtask

   // scoreboard model: expected word with the model's own toggle bit
   task automatic want(input logic press, input logic [7:0] code, input int dt);
      tog = ~tog;
      exp_q.push_back({tog, press, 1'b0, code});
      exp_dt_q.push_back(dt);
   endtask

   task automatic drain(input string nm);
      logic [10:0] w;
      logic [10:0] e;
      int t;
      int d;
      int k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         d = exp_dt_q.pop_front();
         get_ev(w, t);
         chk($sformatf("%s_ev%0d", nm, k), {21'd0, w}, {21'd0, e});
         if (d >= 0) chk($sformatf("%s_dt%0d", nm, k), t - last_t, d);
         last_t = t;
         k++;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk_sys);
         n++;
      end
      chk(nm, {31'd0, busy}, 32'd0);
   endtask

   logic [7:0] burst_ch[17];
   logic [7:0] burst_sc[16];
   logic       rdy[17];
   int         acc;
   int         acc2;
   int         rel_t;
   int         n_acc;

   initial begin
      burst_ch = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                   8'h38, 8'h39, 8'h20, 8'h0D, 8'h08, 8'h2C, 8'h2E, 8'h2F, 8'h3B};
      burst_sc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                   8'h3E, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h41, 8'h49, 8'h4A};
      reset      = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
`ifdef PS2_AUTOTYPE_ABORT_EN
      abort      = 1'b0;
`endif
      repeat (3) @(negedge clk_sys);
      chk("rst_key", {21'd0, ps2_key}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, char_ready}, 32'd1);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);

      // 'A': press 1C three edges after acceptance, release 8 later
      send_char(8'h41, acc);
      last_t = acc;
      want(1'b1, 8'h1C, 3);
      want(1'b0, 8'h1C, 8);
      drain("A");
      rel_t = last_t;
      while (cyc < rel_t + 7) @(negedge clk_sys);
      chk("A_busy_hold", {31'd0, busy}, 32'd1);
      @(negedge clk_sys);
      chk("A_busy_drop", {31'd0, busy}, 32'd0);

      // '@': shift wrapped around 1E
      repeat (4) @(negedge clk_sys);
      send_char(8'h40, acc);
      last_t = acc;
      want(1'b1, 8'h12, 3);
      want(1'b1, 8'h1E, 8);
      want(1'b0, 8'h1E, 8);
      want(1'b0, 8'h12, 8);
      drain("at");
      wait_idle("at_idle");

      // '~' is dropped, 'z' types 1A
      send_char(8'h7E, acc);
      send_char(8'h7A, acc2);
      want(1'b1, 8'h1A, -1);
      want(1'b0, 8'h1A, 8);
      drain("z");
      chk("drop_one", {24'd0, drop_cnt}, 32'd1);
      wait_idle("z_idle");
      chk("z_no_extra", ev_q.size(), 32'd0);

      // FIFO fill: 16 accepted while 'X' is typing, the 17th refused
      send_char(8'h58, acc);
      last_t = acc;
      want(1'b1, 8'h22, 3);
      drain("X");
      for (int i = 0; i < 17; i++) begin
         char_in    = burst_ch[i];
         char_valid = 1'b1;
         rdy[i]     = char_ready;
         @(negedge clk_sys);
      end
      char_valid = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 16; i++) if (rdy[i]) n_acc++;
      chk("fill_accepted", n_acc, 32'd16);
      chk("fill_17th_ready", {31'd0, rdy[16]}, 32'd0);
      want(1'b0, 8'h22, 8);
      for (int i = 0; i < 16; i++) begin
         want(1'b1, burst_sc[i], 10);
         want(1'b0, burst_sc[i], 8);
      end
      drain("burst");
      wait_idle("burst_idle");
      chk("burst_no_extra", ev_q.size(), 32'd0);

      // reset while a key is held and another char is queued
      send_char(8'h61, acc);
      last_t = acc;
      want(1'b1, 8'h1C, 3);
      drain("a");
      send_char(8'h62, acc);
      repeat (2) @(negedge clk_sys);
      reset = 1'b1;
      #1;
      chk("mid_rst_key", {21'd0, ps2_key}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, char_ready}, 32'd1);
      chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      tog   = 1'b0;
      ev_q.delete();
      ev_t.delete();
      repeat (40) @(negedge clk_sys);
      chk("post_rst_events", ev_q.size(), 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef PS2_AUTOTYPE_ABORT_EN
      // abort during KEY_DN of ':' releases 4C at once, then shift after gap
      send_char(8'h3A, acc);
      last_t = acc;
      want(1'b1, 8'h12, 3);
      want(1'b1, 8'h4C, 8);
      drain("colon");
      send_char(8'h71, acc);
      abort = 1'b1;
      #1;
      chk("abort_ready", {31'd0, char_ready}, 32'd0);
      @(negedge clk_sys);
      last_t = cyc;
      abort  = 1'b0;
      want(1'b0, 8'h4C, 0);
      want(1'b0, 8'h12, 8);
      drain("abort");
      wait_idle("abort_idle");
      repeat (40) @(negedge clk_sys);
      chk("abort_flushed", ev_q.size(), 32'd0);
      chk("abort_state", {29'd0, fsm_state}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
